mult_result_accum: RTL
======================

# mult_result_accum

Downstream consumer of the 8-bit serial multiplier. Watches the multiplier's `result_valid`/`result`, and pulses `get` to retire each product. Sums a fixed number of consecutive products (a dot product of length `LEN`) into a wide accumulator, then presents the sum to the next stage over a valid/ready handshake. While a sum is waiting to be taken, the block stalls the multiplier by withholding `get`.

## Interface
Parameters:
- `ACC_W`, 24: accumulator and output width; legal 16..32.
- `LEN`, 4: products per sum; legal 1..255.

Ports:
- `clk`: input, 1 bit. Single clock; all state changes on its rising edge.
- `rst_b`: input, 1 bit. Reset is synchronous and active-low.
- `result_valid`: input, 1 bit. Multiplier has a product available.
- `result`: input, 16 bits. Unsigned product, stable while `result_valid` is high.
- `get`: output, 1 bit. Registered one-cycle pulse that retires the current product.
- `out_valid`: output, 1 bit. Sum available.
- `out_ready`: input, 1 bit. Downstream accepts the sum.
- `out_sum`: output, `ACC_W` bits. Accumulator contents.
- `out_ovf`: output, 1 bit. Sticky overflow flag for the current sum.

## Operation
- FSM with three states: WAIT, TAKE, EMIT.
- WAIT
  - `get`=0, `out_valid`=0.
  - If `result_valid`=1, go to TAKE; else stay in WAIT.
- TAKE (always exactly one cycle)
  - `get`=1.
  - At the closing edge: `acc <= acc + result`, `cnt <= cnt + 1`.
  - If the incremented `cnt` == `LEN`, go to EMIT; else go to WAIT.
  - `result` is sampled in the same cycle `get` is high; the multiplier drops `result_valid` on that edge, so WAIT never sees the same product twice.
- EMIT
  - `out_valid`=1, `get`=0; the multiplier is back-pressured.
  - On `out_ready`=1: `acc <= 0`, `cnt <= 0`, `out_ovf <= 0`, go to WAIT.
- Arithmetic
  - `result` is zero-extended to `ACC_W+1` bits before the add.
  - A carry out of bit `ACC_W-1` sets `out_ovf`; it stays set until the sum is accepted.
  - `out_sum` is driven directly by the `acc` register.
- Counter: `cnt` width is `$clog2(LEN+1)`.

## Timing
Reset values (any cycle with `rst_b`=0 at the edge):
- State = WAIT, `acc`=0, `cnt`=0.
- `get`=0, `out_valid`=0, `out_sum`=0, `out_ovf`=0.

Latency:
- `result_valid` first seen high in cycle t → `get` high in cycle t+1.
- Sum update is visible in cycle t+2.
- For the LEN-th product, `out_valid`=1 from cycle t+2.
- Throughput is bounded by the multiplier: at most one product per 2 cycles.

Boundary conditions:
- `LEN`=1: every product goes WAIT → TAKE → EMIT.
- EMIT with `out_ready`=1 and `result_valid`=1 in the same cycle: hand-off happens; the next cycle is WAIT, and TAKE follows one cycle later. No product is lost.
- `out_ready` held high outside EMIT: ignored.
- Reset mid-sum or during EMIT: partial sum is discarded. The multiplier shares `rst_b`, so no product is orphaned.
- All outputs are registered or decoded from state only. There is no combinational path from `result_valid`/`out_ready` to `get`/`out_valid`.

## Configuration
- `MULT_ACC_SAT_EN` defined:
  - On carry, `acc` saturates to all-ones and further adds keep it there.
  - `out_ovf` is set as usual.
- `MULT_ACC_SAT_EN` not defined:
  - `acc` wraps modulo 2^`ACC_W`.
  - `out_ovf` is still set.

## Structure
- Shared package `mult_pkg` holds:
  - the state enum (WAIT, TAKE, EMIT);
  - the 16-bit product width constant;
  - the default `ACC_W`/`LEN` constants shared with the multiplier test environment.
- One sub-module, `mult_acc_add`: combinational zero-extend, add and carry. It contains the `MULT_ACC_SAT_EN` saturation mux, so the top level has no `ifdef`.
- The top level holds the FSM, counter and registers.

## Test plan
- **Reset:** `rst_b`=0 for 2 cycles mid-accumulation (acc=0x1234, cnt=2) → next cycle all outputs 0, state WAIT, `get` stays 0.
- **Basic sum:** `LEN`=4, products 0x0010, 0x0020, 0x0030, 0x0040, `out_ready`=1 → `out_sum`=0x0000A0 with `out_valid` for 1 cycle, `out_ovf`=0, exactly 4 `get` pulses, each 1 cycle wide.
- **Back-pressure:** hold `out_ready`=0 for 10 cycles after a sum → `out_valid` and `out_sum` stable, no `get` while the multiplier's `result_valid`=1. Release → `get` pulse 2 cycles after `out_ready`.
- **Overflow:** `ACC_W`=16, `LEN`=2, products 0xFFFF, 0x0002:
  - without `MULT_ACC_SAT_EN` → `out_sum`=0x0001, `out_ovf`=1;
  - with it → `out_sum`=0xFFFF, `out_ovf`=1;
  - `out_ovf` returns to 0 after acceptance.
- **LEN=1 and simultaneous hand-off:** `LEN`=1 with `result_valid` high during EMIT and `out_ready`=1 → no duplicate take. Sums 0x0005, 0x0007 emitted in order.
- **End-to-end:** chain with the serial multiplier, 20 random operand pairs, `LEN`=5 → each `out_sum` equals the reference dot product.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the 8-bit serial multiplier and its result accumulator:
// product width, default accumulator sizing and the accumulator FSM states.
package mult_pkg;

  localparam int PROD_W    = 16;
  localparam int DEF_ACC_W = 24;
  localparam int DEF_LEN   = 4;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    TAKE = 2'd1,
    EMIT = 2'd2
  } acc_state_e;

endpackage

// File: rtl/mult_acc_add.sv
// Combinational accumulate step: zero-extend the product, add it, report the carry.
// Saturates to all-ones on carry when MULT_ACC_SAT_EN is defined, otherwise wraps.
module mult_acc_add
  import mult_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] sum_ext;

  always_comb begin
    sum_ext = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    carry   = sum_ext[ACC_W];
`ifdef MULT_ACC_SAT_EN
    // Once saturated, any further non-zero add carries again and keeps it pinned.
    sum     = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    sum     = sum_ext[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/mult_result_accum.sv
// Sums LEN consecutive multiplier products and hands the sum downstream over valid/ready.
// Overflow behaviour is selected in mult_acc_add via MULT_ACC_SAT_EN.
module mult_result_accum
  import mult_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int LEN   = DEF_LEN
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              result_valid,
  input  logic [PROD_W-1:0] result,
  output logic              get,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int              CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, add_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             ovf_q, ovf_d, add_carry;

  mult_acc_add #(.ACC_W(ACC_W)) u_add (
    .acc   (acc_q),
    .prod  (result),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      WAIT: begin
        if (result_valid) state_d = TAKE;
      end
      TAKE: begin
        acc_d   = add_sum;
        cnt_d   = cnt_inc;
        ovf_d   = ovf_q | add_carry;
        state_d = (cnt_inc == LEN_C) ? EMIT : WAIT;
      end
      EMIT: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = WAIT;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= WAIT;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs decode registered state only, so no input reaches them combinationally.
  assign get       = (state_q == TAKE);
  assign out_valid = (state_q == EMIT);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule
